// File: rtl/traffic_phase_sequencer.sv
// Traffic phase sequencer: green/yellow/all-red rotation over N_APPR approaches,
// with power-up lamp test, pedestrian walk service and flashing-yellow maintenance mode.
module traffic_phase_sequencer #(
    parameter int unsigned N_APPR      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned LAMP_CYC    = 2,
    parameter int unsigned STARTUP_CYC = 250000000,
    parameter int unsigned GREEN_CYC   = 500000000,
    parameter int unsigned YELLOW_CYC  = 200000000,
    parameter int unsigned ALLRED_CYC  = 100000000,
    parameter int unsigned FLASH_CYC   = 50000000,
    localparam int unsigned IDX_W      = (N_APPR > 2) ? $clog2(N_APPR) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_APPR-1:0] ped_req,
    input  logic              flash_en,
    output logic [N_APPR-1:0] red,
    output logic [N_APPR-1:0] yellow,
    output logic [N_APPR-1:0] green,
    output logic [N_APPR-1:0] ped_walk,
    output logic              buzzer,
    output logic [IDX_W-1:0]  active_idx
);

    typedef enum logic [2:0] {
        S_LAMPTEST,
        S_STARTUP,
        S_GREEN,
        S_YELLOW,
        S_ALLRED,
        S_FLASH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   dur_m1;
    logic               tdone;
    logic [IDX_W-1:0]   idx_d, idx_next;
    logic [N_APPR-1:0]  pending_q, pending_d;
    logic [N_APPR-1:0]  ign;
    logic [N_APPR-1:0]  sel;
    logic               phase_q, phase_d;
    logic [N_APPR-1:0]  red_d, yellow_d, green_d, walk_d;

    // Terminal count of the phase currently running
    always_comb begin
        dur_m1 = CNT_W'(LAMP_CYC - 1);
        case (state_q)
            S_LAMPTEST: dur_m1 = CNT_W'(LAMP_CYC - 1);
            S_STARTUP:  dur_m1 = CNT_W'(STARTUP_CYC - 1);
            S_GREEN:    dur_m1 = CNT_W'(GREEN_CYC - 1);
            S_YELLOW:   dur_m1 = CNT_W'(YELLOW_CYC - 1);
            S_ALLRED:   dur_m1 = CNT_W'(ALLRED_CYC - 1);
            S_FLASH:    dur_m1 = CNT_W'(FLASH_CYC - 1);
            default:    dur_m1 = CNT_W'(LAMP_CYC - 1);
        endcase
        tdone = (timer_q == dur_m1);
    end

    assign idx_next = (active_idx == IDX_W'(N_APPR - 1)) ? '0 : active_idx + IDX_W'(1);

    // Next state, timer, pending bookkeeping and output decode of the next state
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + CNT_W'(1);
        idx_d    = active_idx;
        phase_d  = phase_q;
        walk_d   = ped_walk;
        ign      = (state_q == S_GREEN) ? ped_walk : '0;
        pending_d = pending_q | (ped_req & ~ign);
        red_d    = '0;
        yellow_d = '0;
        green_d  = '0;

        case (state_q)
            S_LAMPTEST: if (tdone) state_d = flash_en ? S_FLASH : S_STARTUP;
            S_STARTUP:  if (tdone) state_d = S_GREEN;
            S_GREEN:    if (tdone) state_d = S_YELLOW;
            S_YELLOW:   if (tdone) state_d = S_ALLRED;
            S_ALLRED:   if (tdone) state_d = S_GREEN;
            S_FLASH: begin
                if (!flash_en) begin
                    state_d = S_STARTUP;
                end else if (tdone) begin
                    timer_d = '0;
                    phase_d = ~phase_q;
                end
            end
            default:    state_d = S_LAMPTEST;
        endcase

        // Maintenance request aborts any running phase except the lamp test
        if (flash_en && (state_q inside {S_STARTUP, S_GREEN, S_YELLOW, S_ALLRED}))
            state_d = S_FLASH;

        if (state_d != state_q) begin
            timer_d = '0;
            if (state_d == S_FLASH)   phase_d = 1'b1;
            if (state_d == S_STARTUP) idx_d = '0;
            if (state_q == S_ALLRED && state_d == S_GREEN) idx_d = idx_next;
            if (state_q == S_STARTUP && state_d == S_GREEN) idx_d = '0;
        end

        sel = N_APPR'(1) << idx_d;

        // Walk is granted only on green entry and held for the whole green
        if (state_d == S_GREEN && state_q != S_GREEN) begin
            walk_d    = sel & (pending_q | ped_req);
            pending_d = pending_d & ~sel;
        end else if (state_d != S_GREEN) begin
            walk_d = '0;
        end

        case (state_d)
            S_LAMPTEST: begin
                red_d    = '1;
                yellow_d = '1;
                green_d  = '1;
            end
            S_STARTUP, S_ALLRED: red_d = '1;
            S_GREEN: begin
                green_d = sel;
                red_d   = ~sel;
            end
            S_YELLOW: begin
                yellow_d = sel;
                red_d    = ~sel;
            end
            S_FLASH:  yellow_d = {N_APPR{phase_d}};
            default:  red_d = '1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_LAMPTEST;
            timer_q    <= '0;
            active_idx <= '0;
            pending_q  <= '0;
            phase_q    <= 1'b1;
            red        <= '1;
            yellow     <= '1;
            green      <= '1;
            ped_walk   <= '0;
            buzzer     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            active_idx <= idx_d;
            pending_q  <= pending_d;
            phase_q    <= phase_d;
            red        <= red_d;
            yellow     <= yellow_d;
            green      <= green_d;
            ped_walk   <= walk_d;
            buzzer     <= |walk_d;
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: segment tables of expected lamp
// states applied cycle by cycle, plus hand-written reset corner cases.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ped_req;
    logic       flash_en;
    logic [3:0] red, yellow, green, ped_walk;
    logic       buzzer;
    logic [1:0] active_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .N_APPR(4), .CNT_W(8), .LAMP_CYC(2), .STARTUP_CYC(3), .GREEN_CYC(5),
        .YELLOW_CYC(2), .ALLRED_CYC(1), .FLASH_CYC(4)
    ) dut (
        .clk(clk), .reset(reset), .ped_req(ped_req), .flash_en(flash_en),
        .red(red), .yellow(yellow), .green(green), .ped_walk(ped_walk),
        .buzzer(buzzer), .active_idx(active_idx)
    );

    typedef struct {
        logic [3:0] req;
        logic       fl;
        logic [3:0] r, y, g, w;
        logic       bz;
        logic [1:0] ix;
        int         len;
        logic       inv;
    } seg_t;

    seg_t segs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] ix);
        return 4'(1) << ix;
    endfunction

    task automatic add(input logic [3:0] r, input logic [3:0] y, input logic [3:0] g,
                       input logic [3:0] w, input logic [1:0] ix, input int len,
                       input logic [3:0] req, input logic fl, input logic inv);
        seg_t s;
        s.req = req; s.fl = fl; s.r = r; s.y = y; s.g = g; s.w = w;
        s.bz = |w; s.ix = ix; s.len = len; s.inv = inv;
        segs.push_back(s);
    endtask

    task automatic add_lamp(input int len, input logic fl);
        add(4'hF, 4'hF, 4'hF, 4'h0, 2'd0, len, 4'h0, fl, 1'b0);
    endtask
    task automatic add_start(input int len);
        add(4'hF, 4'h0, 4'h0, 4'h0, 2'd0, len, 4'h0, 1'b0, 1'b1);
    endtask
    task automatic add_green(input logic [1:0] ix, input logic [3:0] w, input int len,
                             input logic [3:0] req, input logic fl);
        add(~oh(ix), 4'h0, oh(ix), w, ix, len, req, fl, 1'b1);
    endtask
    task automatic add_yel(input logic [1:0] ix, input int len);
        add(~oh(ix), oh(ix), 4'h0, 4'h0, ix, len, 4'h0, 1'b0, 1'b1);
    endtask
    task automatic add_ar(input logic [1:0] ix, input logic [3:0] req);
        add(4'hF, 4'h0, 4'h0, 4'h0, ix, 1, req, 1'b0, 1'b1);
    endtask
    task automatic add_flash(input logic ph, input logic [1:0] ix, input int len,
                             input logic [3:0] req, input logic fl);
        add(4'h0, {4{ph}}, 4'h0, 4'h0, ix, len, req, fl, 1'b0);
    endtask
    task automatic add_cycle(input logic [1:0] ix, input logic [3:0] w);
        add_green(ix, w, 5, 4'h0, 1'b0);
        add_yel(ix, 2);
        add_ar(ix, 4'h0);
    endtask
    task automatic add_basic();
        add_lamp(2, 1'b0);
        add_start(3);
        for (int i = 0; i < 4; i++) add_cycle(2'(i), 4'h0);
        add_green(2'd0, 4'h0, 5, 4'h0, 1'b0);
    endtask

    task automatic check_reset_lamps(input string tag);
        chk({tag, ".red"},  32'(red),        32'hF);
        chk({tag, ".yel"},  32'(yellow),     32'hF);
        chk({tag, ".grn"},  32'(green),      32'hF);
        chk({tag, ".walk"}, 32'(ped_walk),   32'h0);
        chk({tag, ".buz"},  32'(buzzer),     32'h0);
        chk({tag, ".idx"},  32'(active_idx), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; ped_req = 4'h0; flash_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_lamps({tag, ".inrst"});
        reset = 1'b0;
    endtask

    task automatic run_segs(input string tag);
        int cyc = 0;
        foreach (segs[s]) begin
            for (int j = 0; j < segs[s].len; j++) begin
                chk($sformatf("%s.c%0d.red",  tag, cyc), 32'(red),        32'(segs[s].r));
                chk($sformatf("%s.c%0d.yel",  tag, cyc), 32'(yellow),     32'(segs[s].y));
                chk($sformatf("%s.c%0d.grn",  tag, cyc), 32'(green),      32'(segs[s].g));
                chk($sformatf("%s.c%0d.walk", tag, cyc), 32'(ped_walk),   32'(segs[s].w));
                chk($sformatf("%s.c%0d.buz",  tag, cyc), 32'(buzzer),     32'(segs[s].bz));
                chk($sformatf("%s.c%0d.idx",  tag, cyc), 32'(active_idx), 32'(segs[s].ix));
                if (segs[s].inv)
                    chk($sformatf("%s.c%0d.onehot", tag, cyc),
                        32'($countones(green | yellow) <= 1), 32'(1));
                chk($sformatf("%s.c%0d.walkgrn", tag, cyc), 32'(ped_walk & ~green), 32'h0);
                ped_req  = segs[s].req;
                flash_en = segs[s].fl;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        segs.delete();
        ped_req  = 4'h0;
        flash_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ped_req = 4'h0; flash_en = 1'b0;

        // Plain rotation from reset, including index wrap
        do_reset("seq");
        add_basic();
        run_segs("seq");

        // Pedestrian pulse during GREEN(0) served at GREEN(2)
        do_reset("ped2");
        add_lamp(2, 1'b0);
        add_start(3);
        add_green(2'd0, 4'h0, 1, 4'h0, 1'b0);
        add_green(2'd0, 4'h0, 1, 4'b0100, 1'b0);
        add_green(2'd0, 4'h0, 3, 4'h0, 1'b0);
        add_yel(2'd0, 2);
        add_ar(2'd0, 4'h0);
        add_cycle(2'd1, 4'h0);
        add_cycle(2'd2, 4'b0100);
        add_cycle(2'd3, 4'h0);
        add_green(2'd0, 4'h0, 2, 4'h0, 1'b0);
        run_segs("ped2");

        // Request held through GREEN(1): no carry-over; re-request during non-walk green latches
        do_reset("hold1");
        add_lamp(2, 1'b0);
        add_start(3);
        add_green(2'd0, 4'h0, 5, 4'h0, 1'b0);
        add_yel(2'd0, 2);
        add_ar(2'd0, 4'b0010);
        add_green(2'd1, 4'b0010, 5, 4'b0010, 1'b0);
        add_yel(2'd1, 2);
        add_ar(2'd1, 4'h0);
        add_cycle(2'd2, 4'h0);
        add_cycle(2'd3, 4'h0);
        add_cycle(2'd0, 4'h0);
        add_green(2'd1, 4'h0, 1, 4'h0, 1'b0);
        add_green(2'd1, 4'h0, 1, 4'b0010, 1'b0);
        add_green(2'd1, 4'h0, 3, 4'h0, 1'b0);
        add_yel(2'd1, 2);
        add_ar(2'd1, 4'h0);
        add_cycle(2'd2, 4'h0);
        add_cycle(2'd3, 4'h0);
        add_cycle(2'd0, 4'h0);
        add_green(2'd1, 4'b0010, 5, 4'h0, 1'b0);
        add_yel(2'd1, 1);
        run_segs("hold1");

        // Flash from GREEN(1), request retained through flash
        do_reset("flash");
        add_lamp(2, 1'b0);
        add_start(3);
        add_cycle(2'd0, 4'h0);
        add_green(2'd1, 4'h0, 2, 4'h0, 1'b0);
        add_green(2'd1, 4'h0, 1, 4'h0, 1'b1);
        add_flash(1'b1, 2'd1, 2, 4'h0, 1'b1);
        add_flash(1'b1, 2'd1, 1, 4'b1000, 1'b1);
        add_flash(1'b1, 2'd1, 1, 4'h0, 1'b1);
        add_flash(1'b0, 2'd1, 4, 4'h0, 1'b1);
        add_flash(1'b1, 2'd1, 1, 4'h0, 1'b0);
        add_start(3);
        add_cycle(2'd0, 4'h0);
        add_cycle(2'd1, 4'h0);
        add_cycle(2'd2, 4'h0);
        add_green(2'd3, 4'b1000, 5, 4'h0, 1'b0);
        add_yel(2'd3, 1);
        run_segs("flash");

        // flash_en ignored in LAMPTEST, taken when LAMPTEST ends
        do_reset("lampfl");
        add_lamp(2, 1'b1);
        add_flash(1'b1, 2'd0, 4, 4'h0, 1'b1);
        add_flash(1'b0, 2'd0, 1, 4'h0, 1'b0);
        add_start(3);
        add_green(2'd0, 4'h0, 2, 4'h0, 1'b0);
        run_segs("lampfl");

        // Asynchronous reset mid-YELLOW(2) discards progress and pending request
        do_reset("arst");
        add_lamp(2, 1'b0);
        add_start(3);
        add_cycle(2'd0, 4'h0);
        add_cycle(2'd1, 4'h0);
        add_green(2'd2, 4'h0, 2, 4'h0, 1'b0);
        add_green(2'd2, 4'h0, 1, 4'b1000, 1'b0);
        add_green(2'd2, 4'h0, 2, 4'h0, 1'b0);
        add_yel(2'd2, 1);
        run_segs("arst");
        chk("arst.pre_yel", 32'(yellow), 32'h4);
        #2;
        reset = 1'b1;
        #1;
        check_reset_lamps("arst.async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        add_basic();
        run_segs("arst.restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
